// File: rtl/x86_state_reader_pkg.sv
// Shared architectural-state types for the x86 state reader slice.
package x86_state_reader_pkg;

  localparam int unsigned NREG  = 4;
  localparam int unsigned REG_W = 32;
  localparam int unsigned IDX_W = $clog2(NREG);

  typedef struct packed {
    logic [NREG-1:0][REG_W-1:0] r;
  } x86_t;

endpackage

// File: rtl/x86_state_reader_prio_enc.sv
// Lowest-set-bit priority encoder over a register dirty mask.
module x86_prio_enc
  import x86_state_reader_pkg::*;
#(
  parameter int unsigned N   = NREG,
  parameter int unsigned IW  = IDX_W
) (
  input  logic [N-1:0]  mask,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (mask[i] && !any) begin
        idx = IW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/x86_state_reader.sv
// Emits one record per changed register (or all registers on flush) as a
// valid/ready stream, taken from a snapshot frozen at burst start.
module x86_state_reader
  import x86_state_reader_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  x86_t             v,
  input  logic             flush,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [IDX_W-1:0] o_idx,
  output logic [REG_W-1:0] o_data,
  output logic             busy,
  output logic [15:0]      rec_cnt
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e          state_q, state_d;
  x86_t            snap_q, snap_d;
  logic [NREG-1:0] mask_q, mask_d;
  logic            pend_flush_q, pend_flush_d;
  logic [15:0]     rec_cnt_q, rec_cnt_d;

  logic [NREG-1:0]  diff;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;

  x86_prio_enc #(
    .N  (NREG),
    .IW (IDX_W)
  ) u_prio_enc (
    .mask (mask_q),
    .idx  (enc_idx),
    .any  (enc_any)
  );

  always_comb begin
    diff = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      diff[i] = (v.r[i] != snap_q.r[i]);
    end
  end

  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    mask_d       = mask_q;
    pend_flush_d = pend_flush_q;
    rec_cnt_d    = rec_cnt_q;
    o_valid      = 1'b0;
    o_idx        = '0;
    o_data       = '0;
    busy         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (flush || pend_flush_q) begin
          mask_d       = '1;
          snap_d       = v;
          pend_flush_d = 1'b0;
          state_d      = SEND;
        end else if (diff != '0) begin
          mask_d  = diff;
          snap_d  = v;
          state_d = SEND;
        end
      end
      SEND: begin
        busy    = 1'b1;
        o_valid = enc_any;
        o_idx   = enc_idx;
        o_data  = snap_q.r[enc_idx];
        // Flushes arriving mid-burst collapse into a single pending request.
        if (flush) pend_flush_d = 1'b1;
        if (o_ready && enc_any) begin
          mask_d    = mask_q & ~(NREG'(1) << enc_idx);
          rec_cnt_d = rec_cnt_q + 16'd1;
          if (mask_d == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      snap_q       <= '0;
      mask_q       <= '0;
      pend_flush_q <= 1'b0;
      rec_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      mask_q       <= mask_d;
      pend_flush_q <= pend_flush_d;
      rec_cnt_q    <= rec_cnt_d;
    end
  end

  assign rec_cnt = rec_cnt_q;

endmodule

// File: tb/tb_x86_state_reader.sv
// Directed self-checking bench for x86_state_reader.
module tb_x86_state_reader;
  import x86_state_reader_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  x86_t             v;
  logic             flush;
  logic             o_valid;
  logic             o_ready;
  logic [IDX_W-1:0] o_idx;
  logic [REG_W-1:0] o_data;
  logic             busy;
  logic [15:0]      rec_cnt;

  int checks   = 0;
  int failures = 0;

  x86_state_reader dut (
    .clk     (clk),
    .rst     (rst),
    .v       (v),
    .flush   (flush),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_idx   (o_idx),
    .o_data  (o_data),
    .busy    (busy),
    .rec_cnt (rec_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) at negedges for a record, checks it, then steps one cycle.
  task automatic expect_rec(input string tag, input int unsigned idx, input logic [31:0] data);
    int unsigned n = 0;
    while (!o_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_valid"}, 32'(o_valid), 32'd1);
    check_eq({tag, "_idx"}, 32'(o_idx), idx);
    check_eq({tag, "_data"}, o_data, data);
    @(negedge clk);
  endtask

  initial begin
    int seen;
    rst = 1'b0; v = '0; flush = 1'b0; o_ready = 1'b0;
    #2;
    check_eq("rst_valid", 32'(o_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_cnt", 32'(rec_cnt), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1; o_ready = 1'b1;

    // all-zero state held: nothing to report
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_valid) seen++;
    end
    check_eq("zero_no_valid", 32'(seen), 32'd0);
    check_eq("zero_cnt", 32'(rec_cnt), 32'd0);

    // single change, one-cycle latency
    v.r[2] = 32'h5;
    @(negedge clk);
    check_eq("one_valid", 32'(o_valid), 32'd1);
    check_eq("one_idx", 32'(o_idx), 32'd2);
    check_eq("one_data", o_data, 32'h5);
    @(negedge clk);
    check_eq("one_idle_valid", 32'(o_valid), 32'd0);
    check_eq("one_idle_busy", 32'(busy), 32'd0);
    check_eq("one_idle_idx", 32'(o_idx), 32'd0);
    check_eq("one_cnt", 32'(rec_cnt), 32'd1);

    // two changes under backpressure
    o_ready = 1'b0;
    v.r[0] = 32'hA; v.r[3] = 32'hB;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check_eq("bp_hold_idx", 32'(o_idx), 32'd0);
      check_eq("bp_hold_data", o_data, 32'hA);
      check_eq("bp_hold_valid", 32'(o_valid), 32'd1);
      @(negedge clk);
    end
    o_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_second_idx", 32'(o_idx), 32'd3);
    check_eq("bp_second_data", o_data, 32'hB);
    @(negedge clk);
    check_eq("bp_done_valid", 32'(o_valid), 32'd0);
    check_eq("bp_cnt", 32'(rec_cnt), 32'd3);

    // load {1,2,3,4}, drain, then flush emits all four back-to-back
    v.r[0] = 32'd1; v.r[1] = 32'd2; v.r[2] = 32'd3; v.r[3] = 32'd4;
    for (int unsigned i = 0; i < 4; i++) expect_rec("load", i, 32'(i + 1));
    check_eq("load_idle", 32'(o_valid), 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      check_eq("flush_idx", 32'(o_idx), i);
      check_eq("flush_data", o_data, 32'(i + 1));
      check_eq("flush_valid", 32'(o_valid), 32'd1);
      @(negedge clk);
    end
    check_eq("flush_end", 32'(o_valid), 32'd0);
    check_eq("flush_cnt", 32'(rec_cnt), 32'd11);

    // changes during SEND coalesce to the final value
    o_ready = 1'b0;
    v.r[1] = 32'h1;
    @(negedge clk);
    v.r[1] = 32'h2;
    @(negedge clk);
    v.r[1] = 32'h3;
    @(negedge clk);
    check_eq("coal_first_data", o_data, 32'h1);
    o_ready = 1'b1;
    @(negedge clk);
    check_eq("coal_gap", 32'(o_valid), 32'd0);
    expect_rec("coal_final", 1, 32'h3);
    check_eq("coal_end", 32'(o_valid), 32'd0);
    check_eq("coal_cnt", 32'(rec_cnt), 32'd13);

    // flushes during SEND become one full burst afterwards
    o_ready = 1'b0;
    v.r[0] = 32'h7;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_eq("pf_hold_idx", 32'(o_idx), 32'd0);
    o_ready = 1'b1;
    expect_rec("pf_first", 0, 32'h7);
    expect_rec("pf_b0", 0, 32'h7);
    expect_rec("pf_b1", 1, 32'h3);
    expect_rec("pf_b2", 2, 32'h3);
    expect_rec("pf_b3", 3, 32'h4);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (o_valid) seen++;
      @(negedge clk);
    end
    check_eq("pf_single_burst", 32'(seen), 32'd0);
    check_eq("pf_cnt", 32'(rec_cnt), 32'd18);

    // reset mid-burst after one acceptance
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    check_eq("mid_idx_before_rst", 32'(o_idx), 32'd1);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(o_valid), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_cnt", 32'(rec_cnt), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    expect_rec("re_r0", 0, 32'h7);
    expect_rec("re_r1", 1, 32'h3);
    expect_rec("re_r2", 2, 32'h3);
    expect_rec("re_r3", 3, 32'h4);
    check_eq("re_end", 32'(o_valid), 32'd0);
    check_eq("re_cnt", 32'(rec_cnt), 32'd4);

    // counter wrap from a preloaded value
    force dut.rec_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.rec_cnt_q;
    check_eq("wrap_preload", 32'(rec_cnt), 32'h0000_FFFE);
    v.r[2] = 32'h22; v.r[3] = 32'h33;
    expect_rec("wrap_r2", 2, 32'h22);
    check_eq("wrap_ffff", 32'(rec_cnt), 32'h0000_FFFF);
    expect_rec("wrap_r3", 3, 32'h33);
    check_eq("wrap_zero", 32'(rec_cnt), 32'd0);
    check_eq("wrap_end", 32'(o_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
